frv_interrupt_ctrl: RTL and testbench
=====================================

Name: frv_interrupt_ctrl

Overview:
Parametrised successor to the core's single-line interrupt logic. It takes NUM_EXT independent external interrupt channels, each configurable as level or edge, plus NMI, software and timer lines. Pending state is latched, and the highest-priority eligible source is selected. The block drives a stable request/cause pair to the pipeline writeback stage until that stage acknowledges it. It sits beside frv_pipeline inside frv_core and replaces the single external-line-plus-cause-code scheme.

Parameters:
NUM_EXT, 8, number of external interrupt channels (1..32).
EXT_EDGE, {NUM_EXT{1'b0}}, per-channel mode mask: 1 = rising-edge latched, 0 = level.
SYNC_STAGES, 2, input synchroniser depth on all interrupt lines (0..3; 0 = no synchroniser).
EXT_CAUSE_BASE, 16, cause code of channel 0; channel i reports EXT_CAUSE_BASE+i. NUM_EXT+EXT_CAUSE_BASE must be <= 64.

Ports:
g_clk  in  1  clock
g_reset  in  1  synchronous active-high reset
mstatus_mie  in  1  global interrupt enable
mie_meie  in  1  machine external interrupt enable
mie_mtie  in  1  timer interrupt enable
mie_msie  in  1  software interrupt enable
ext_enable  in  NUM_EXT  per-channel enable mask
nmi_line  in  1  non-maskable interrupt line (always edge)
ext_lines  in  NUM_EXT  external interrupt lines
sw_line  in  1  software interrupt line (level)
ti_line  in  1  timer interrupt line (level)
mip_meip  out  1  any external channel pending AND enabled (registered)
mip_mtip  out  1  timer pending (registered)
mip_msip  out  1  software pending (registered)
ext_pending  out  NUM_EXT  per-channel pending vector (registered)
int_trap_req  out  1  request writeback stage to take an interrupt
int_trap_nmi  out  1  current request is the NMI
int_trap_cause  out  6  cause code of the current request
int_trap_ack  in  1  writeback stage has taken the trap

Behaviour:
- Reset: all synchroniser flops, edge history, pending registers, mip_* outputs, ext_pending, int_trap_req, int_trap_nmi and int_trap_cause are 0. The FSM enters IDLE.
- Synchroniser: each line passes through SYNC_STAGES flops. Latency figures below exclude them.
- Pending update on every clock edge:
  - Level channel: pend = sync line.
  - Edge channel and NMI: pend is set on a rising edge (sync & ~prev) and cleared on ack of that source. If set and clear occur in the same cycle, set wins.
  - sw and ti are level only.
- Eligibility:
  - NMI: pend_nmi, independent of all enables.
  - Channel i: pend_i & ext_enable[i] & mie_meie & mstatus_mie.
  - Software: pend_sw & mie_msie & mstatus_mie.
  - Timer: pend_ti & mie_mtie & mstatus_mie.
- Priority, highest first: NMI > external (lowest index first) > software > timer.
- Cause codes: NMI = 0 with int_trap_nmi = 1; ext i = EXT_CAUSE_BASE+i; software = 3; timer = 7.
- FSM IDLE:
  - If any source is eligible, next cycle go to REQ, set int_trap_req = 1, and latch the winner's cause, nmi flag and index.
- FSM REQ:
  - int_trap_req, int_trap_cause and int_trap_nmi are held stable regardless of pending or enable changes. No pre-emption occurs, even by NMI.
  - On int_trap_ack: go to IDLE, deassert int_trap_req next cycle, and clear the latched source's pend if it is edge type. Level sources stay pending until the line drops.
  - The earliest re-request is 1 cycle after returning to IDLE, so req is low for at least one cycle between traps.
- int_trap_ack while in IDLE is ignored.
- Latency (SYNC_STAGES=0): line rises before edge t, pend is set at edge t, int_trap_req is high after edge t+1.
- mip_* and ext_pending are registered copies of the pend state, updated every cycle, including while in REQ.
- g_reset asserted during REQ: req drops at the next edge and all pending is lost.

Decomposition:
- Shared package frv_interrupt_pkg holds:
  - cause constants: CAUSE_NMI = 0, CAUSE_MSI = 3, CAUSE_MTI = 7;
  - the FSM state enum {IDLE, REQ};
  - a 6-bit cause typedef.
- One sub-module, frv_int_sync_edge, parametrised on width, depth and edge mask. It contains the synchroniser, the edge history and the pending latch with set/clear. It is instanced once for the external channels and once for the NMI/sw/ti group.
- The priority select and FSM live in the top.

Test Plan:
- NUM_EXT=8, all enabled, mstatus_mie=1, SYNC_STAGES=0; raise ext_lines[5] and ext_lines[2] together -> int_trap_req=1 two edges later with cause 18. After ack and with both lines held high: cause 18 repeats until line 2 drops, then cause 21.
- EXT_EDGE[3]=1; pulse ext_lines[3] for 1 cycle -> ext_pending[3]=1 and it holds. Ack -> pending[3] clears next cycle and int_trap_req drops. No re-request occurs.
- In REQ with cause 7 (timer), assert nmi_line -> cause stays 7 until ack. After one req-low cycle, req=1 with int_trap_nmi=1 and cause 0.
- With mstatus_mie=0, raise ext/sw/ti -> mip_meip/msip/mtip=1 but int_trap_req stays 0. Pulse nmi_line -> int_trap_req=1 with int_trap_nmi=1.
- SYNC_STAGES=2; edge channel pulse coinciding with an ack of the same channel -> pending remains 1 (set wins) and a second request follows.
- Assert g_reset during REQ -> next edge int_trap_req=0, ext_pending=0, mip_*=0, and the FSM is IDLE.

Source files
------------

// File: rtl/frv_interrupt_pkg.sv
// Shared types and constants for the frv interrupt controller.
package frv_interrupt_pkg;

  typedef logic [5:0] cause_t;

  localparam cause_t CAUSE_NMI = 6'd0;
  localparam cause_t CAUSE_MSI = 6'd3;
  localparam cause_t CAUSE_MTI = 6'd7;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/frv_int_sync_edge.sv
// Input synchroniser, edge history and pending latch for a group of interrupt lines.
// Edge bits latch rising edges until cleared; level bits follow the synchronised line.
module frv_int_sync_edge #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] EDGE_MASK = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] lines,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] pend
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] pend_reg;
  logic [WIDTH-1:0] pend_next;

  generate
    if (DEPTH == 0) begin : g_nosync
      assign sync = lines;
    end else begin : g_sync
      logic [WIDTH-1:0] stage_reg [DEPTH];
      always_ff @(posedge clk) begin
        if (srst) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= lines;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end
      assign sync = stage_reg[DEPTH-1];
    end
  endgenerate

  // A fresh rising edge wins over a clear landing in the same cycle.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pend
      assign pend_next[gi] = EDGE_MASK[gi]
                           ? ((sync[gi] & ~prev_reg[gi]) | (pend_reg[gi] & ~clr[gi]))
                           : sync[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= '0;
      pend_reg <= '0;
    end else begin
      prev_reg <= sync;
      pend_reg <= pend_next;
    end
  end

  assign pend = pend_reg;

endmodule

// File: rtl/frv_interrupt_ctrl.sv
// Multi-source interrupt controller: latches pending state, picks the highest-priority
// eligible source and holds a stable request/cause until writeback acknowledges it.
module frv_interrupt_ctrl
  import frv_interrupt_pkg::*;
#(
  parameter int                 NUM_EXT        = 8,
  parameter logic [NUM_EXT-1:0] EXT_EDGE       = {NUM_EXT{1'b0}},
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 EXT_CAUSE_BASE = 16
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               mstatus_mie,
  input  logic               mie_meie,
  input  logic               mie_mtie,
  input  logic               mie_msie,
  input  logic [NUM_EXT-1:0] ext_enable,
  input  logic               nmi_line,
  input  logic [NUM_EXT-1:0] ext_lines,
  input  logic               sw_line,
  input  logic               ti_line,
  output logic               mip_meip,
  output logic               mip_mtip,
  output logic               mip_msip,
  output logic [NUM_EXT-1:0] ext_pending,
  output logic               int_trap_req,
  output logic               int_trap_nmi,
  output cause_t             int_trap_cause,
  input  logic               int_trap_ack
);

  localparam int IDX_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;

  logic [NUM_EXT-1:0] pend_ext;
  logic [NUM_EXT-1:0] clr_ext;
  logic [2:0]         pend_misc;  // {ti, sw, nmi}
  logic [2:0]         clr_misc;

  frv_int_sync_edge #(
    .WIDTH     (NUM_EXT),
    .DEPTH     (SYNC_STAGES),
    .EDGE_MASK (EXT_EDGE)
  ) u_ext_sync (
    .clk   (g_clk),
    .srst  (g_reset),
    .lines (ext_lines),
    .clr   (clr_ext),
    .pend  (pend_ext)
  );

  frv_int_sync_edge #(
    .WIDTH     (3),
    .DEPTH     (SYNC_STAGES),
    .EDGE_MASK (3'b001)
  ) u_misc_sync (
    .clk   (g_clk),
    .srst  (g_reset),
    .lines ({ti_line, sw_line, nmi_line}),
    .clr   (clr_misc),
    .pend  (pend_misc)
  );

  logic [NUM_EXT-1:0] elig_ext;
  logic               elig_nmi;
  logic               elig_sw;
  logic               elig_ti;

  assign elig_nmi = pend_misc[0];
  assign elig_ext = pend_ext & ext_enable & {NUM_EXT{mie_meie & mstatus_mie}};
  assign elig_sw  = pend_misc[1] & mie_msie & mstatus_mie;
  assign elig_ti  = pend_misc[2] & mie_mtie & mstatus_mie;

  logic             sel_valid;
  logic             sel_nmi;
  logic             sel_ext;
  logic [IDX_W-1:0] sel_idx;
  cause_t           sel_cause;

  always_comb begin
    sel_valid = 1'b0;
    sel_nmi   = 1'b0;
    sel_ext   = 1'b0;
    sel_idx   = '0;
    sel_cause = CAUSE_NMI;
    if (elig_nmi) begin
      sel_valid = 1'b1;
      sel_nmi   = 1'b1;
    end else if (|elig_ext) begin
      sel_valid = 1'b1;
      sel_ext   = 1'b1;
      // Scan downwards so the lowest eligible index is the last one written.
      for (int i = NUM_EXT - 1; i >= 0; i--) begin
        if (elig_ext[i]) begin
          sel_idx   = IDX_W'(i);
          sel_cause = cause_t'(EXT_CAUSE_BASE + i);
        end
      end
    end else if (elig_sw) begin
      sel_valid = 1'b1;
      sel_cause = CAUSE_MSI;
    end else if (elig_ti) begin
      sel_valid = 1'b1;
      sel_cause = CAUSE_MTI;
    end
  end

  state_t           state_reg, state_next;
  cause_t           cause_reg, cause_next;
  logic             nmi_reg, nmi_next;
  logic             ext_src_reg, ext_src_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             take;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_reg   <= IDLE;
      cause_reg   <= CAUSE_NMI;
      nmi_reg     <= 1'b0;
      ext_src_reg <= 1'b0;
      idx_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cause_reg   <= cause_next;
      nmi_reg     <= nmi_next;
      ext_src_reg <= ext_src_next;
      idx_reg     <= idx_next;
    end
  end

  // The latched source is frozen for the whole of REQ; nothing pre-empts it.
  always_comb begin
    state_next   = state_reg;
    cause_next   = cause_reg;
    nmi_next     = nmi_reg;
    ext_src_next = ext_src_reg;
    idx_next     = idx_reg;
    take         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          state_next   = REQ;
          cause_next   = sel_cause;
          nmi_next     = sel_nmi;
          ext_src_next = sel_ext;
          idx_next     = sel_idx;
        end
      end
      REQ: begin
        if (int_trap_ack) begin
          state_next = IDLE;
          take       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Clears only affect edge-type bits; level bits ignore them inside the latch.
  assign clr_ext  = (take && ext_src_reg) ? (NUM_EXT'(1) << idx_reg) : '0;
  assign clr_misc = {2'b00, take & nmi_reg};

  logic meip_reg;

  always_ff @(posedge g_clk) begin
    if (g_reset) meip_reg <= 1'b0;
    else         meip_reg <= |(pend_ext & ext_enable);
  end

  assign mip_meip       = meip_reg;
  assign mip_mtip       = pend_misc[2];
  assign mip_msip       = pend_misc[1];
  assign ext_pending    = pend_ext;
  assign int_trap_req   = (state_reg == REQ);
  assign int_trap_nmi   = nmi_reg;
  assign int_trap_cause = cause_reg;

endmodule

// File: tb/tb_frv_interrupt_ctrl.sv
// Self-checking bench: table-driven priority vectors plus hand-written multi-cycle sequences.
module tb_frv_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mstatus_mie, mie_meie, mie_mtie, mie_msie;
  logic [7:0] ext_enable, ext_lines;
  logic       nmi_line, sw_line, ti_line;
  logic       ack0, ack1;

  logic       meip0, mtip0, msip0, req0, nmi0;
  logic [7:0] pend0;
  logic [5:0] cause0;
  logic       meip1, mtip1, msip1, req1, nmi1;
  logic [7:0] pend1;
  logic [5:0] cause1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frv_interrupt_ctrl #(
    .NUM_EXT(8), .EXT_EDGE(8'h08), .SYNC_STAGES(0), .EXT_CAUSE_BASE(16)
  ) dut (
    .g_clk(clk), .g_reset(rst), .mstatus_mie(mstatus_mie), .mie_meie(mie_meie),
    .mie_mtie(mie_mtie), .mie_msie(mie_msie), .ext_enable(ext_enable),
    .nmi_line(nmi_line), .ext_lines(ext_lines), .sw_line(sw_line), .ti_line(ti_line),
    .mip_meip(meip0), .mip_mtip(mtip0), .mip_msip(msip0), .ext_pending(pend0),
    .int_trap_req(req0), .int_trap_nmi(nmi0), .int_trap_cause(cause0),
    .int_trap_ack(ack0)
  );

  frv_interrupt_ctrl #(
    .NUM_EXT(8), .EXT_EDGE(8'h08), .SYNC_STAGES(2), .EXT_CAUSE_BASE(16)
  ) dut_sync (
    .g_clk(clk), .g_reset(rst), .mstatus_mie(mstatus_mie), .mie_meie(mie_meie),
    .mie_mtie(mie_mtie), .mie_msie(mie_msie), .ext_enable(ext_enable),
    .nmi_line(nmi_line), .ext_lines(ext_lines), .sw_line(sw_line), .ti_line(ti_line),
    .mip_meip(meip1), .mip_mtip(mtip1), .mip_msip(msip1), .ext_pending(pend1),
    .int_trap_req(req1), .int_trap_nmi(nmi1), .int_trap_cause(cause1),
    .int_trap_ack(ack1)
  );

  typedef struct {
    logic       mstatus, meie, mtie, msie;
    logic [7:0] en, ext;
    logic       sw, ti;
    logic       req;
    logic [5:0] cause;
  } vec_t;

  typedef struct {
    logic       req;
    logic [5:0] cause;
    logic       meip, msip, mtip;
    logic [7:0] pend;
  } exp_t;

  vec_t vecs [11];
  exp_t sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    mstatus_mie = 1'b1; mie_meie = 1'b1; mie_mtie = 1'b1; mie_msie = 1'b1;
    ext_enable = 8'hff; ext_lines = 8'h00;
    nmi_line = 1'b0; sw_line = 1'b0; ti_line = 1'b0;
    ack0 = 1'b0; ack1 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;

    //          mst   meie  mtie  msie  en     ext    sw    ti    req   cause
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 8'h24, 1'b0, 1'b0, 1'b1, 6'd18};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 8'h80, 1'b0, 1'b0, 1'b1, 6'd23};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 8'h00, 1'b1, 1'b1, 1'b1, 6'd3};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 8'h00, 1'b0, 1'b1, 1'b1, 6'd7};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 8'h01, 1'b1, 1'b1, 1'b1, 6'd16};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hff, 8'hff, 1'b1, 1'b1, 1'b0, 6'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hfd, 8'h06, 1'b0, 1'b0, 1'b1, 6'd18};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hff, 8'h01, 1'b0, 1'b1, 1'b1, 6'd7};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hff, 8'h00, 1'b0, 1'b1, 1'b0, 6'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hff, 8'h00, 1'b1, 1'b1, 1'b1, 6'd7};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 8'h08, 1'b0, 1'b0, 1'b1, 6'd19};

    // Reset state, and an ack while idle must not start anything.
    do_reset();
    check("rst_req", req0, 0);
    check("rst_nmi", nmi0, 0);
    check("rst_cause", cause0, 0);
    check("rst_pend", pend0, 0);
    check("rst_mip", {meip0, msip0, mtip0}, 0);
    ack0 = 1'b1;
    tick();
    tick();
    check("idle_ack_req", req0, 0);
    ack0 = 1'b0;
    $display("[TB] reset/idle-ack checks done");

    for (int v = 0; v < 11; v++) begin
      do_reset();
      mstatus_mie = vecs[v].mstatus; mie_meie = vecs[v].meie;
      mie_mtie = vecs[v].mtie; mie_msie = vecs[v].msie;
      ext_enable = vecs[v].en; ext_lines = vecs[v].ext;
      sw_line = vecs[v].sw; ti_line = vecs[v].ti;
      e.req   = vecs[v].req;
      e.cause = vecs[v].cause;
      e.meip  = |(vecs[v].ext & vecs[v].en);
      e.msip  = vecs[v].sw;
      e.mtip  = vecs[v].ti;
      e.pend  = vecs[v].ext;
      sb.push_back(e);
      tick();
      check("vec_req_early", req0, 0);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d_req", v), req0, e.req);
      if (e.req) check($sformatf("vec%0d_cause", v), cause0, e.cause);
      check($sformatf("vec%0d_nmi", v), nmi0, 0);
      check($sformatf("vec%0d_mip", v), {meip0, msip0, mtip0}, {e.meip, e.msip, e.mtip});
      check($sformatf("vec%0d_pend", v), pend0, e.pend);
      $display("[TB] vec %0d ext=%02h sw=%0b ti=%0b -> req=%0b cause=%0d",
               v, vecs[v].ext, vecs[v].sw, vecs[v].ti, req0, cause0);
    end

    // Level channels keep re-requesting until their line drops.
    do_reset();
    ext_lines = 8'h24;
    tick(); tick();
    check("lvl_req1", req0, 1);
    check("lvl_cause1", cause0, 18);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    check("lvl_gap1", req0, 0);
    tick();
    check("lvl_req2", req0, 1);
    check("lvl_cause2", cause0, 18);
    ack0 = 1'b1; ext_lines = 8'h20; tick(); ack0 = 1'b0;
    check("lvl_gap2", req0, 0);
    tick();
    check("lvl_req3", req0, 1);
    check("lvl_cause3", cause0, 21);
    $display("[TB] level re-request sequence done");

    // Edge channel: a single-cycle pulse is held until acked, then no re-request.
    do_reset();
    ext_lines = 8'h08;
    tick();
    ext_lines = 8'h00;
    check("edge_pend_set", pend0[3], 1);
    tick();
    check("edge_req", req0, 1);
    check("edge_cause", cause0, 19);
    tick(); tick();
    check("edge_pend_hold", pend0[3], 1);
    check("edge_req_hold", req0, 1);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    check("edge_pend_clr", pend0[3], 0);
    check("edge_req_drop", req0, 0);
    tick(); tick(); tick();
    check("edge_no_rereq", req0, 0);
    $display("[TB] edge pulse sequence done");

    // No pre-emption: NMI raised during a timer request waits for the ack.
    do_reset();
    ti_line = 1'b1;
    tick(); tick();
    check("pre_cause_ti", cause0, 7);
    nmi_line = 1'b1; tick(); nmi_line = 1'b0; tick();
    check("pre_req_held", req0, 1);
    check("pre_cause_held", cause0, 7);
    check("pre_nmi_held", nmi0, 0);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    check("pre_gap", req0, 0);
    tick();
    check("nmi_req", req0, 1);
    check("nmi_flag", nmi0, 1);
    check("nmi_cause", cause0, 0);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    tick();
    check("ti_after_nmi_req", req0, 1);
    check("ti_after_nmi_cause", cause0, 7);
    check("ti_after_nmi_flag", nmi0, 0);
    $display("[TB] NMI no-pre-emption sequence done");

    // Global disable masks everything except NMI.
    do_reset();
    mstatus_mie = 1'b0; ext_lines = 8'h01; sw_line = 1'b1; ti_line = 1'b1;
    tick(); tick();
    check("gdis_mip", {meip0, msip0, mtip0}, 3'b111);
    check("gdis_req", req0, 0);
    nmi_line = 1'b1; tick(); nmi_line = 1'b0; tick();
    check("gdis_nmi_req", req0, 1);
    check("gdis_nmi_flag", nmi0, 1);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    tick(); tick();
    check("gdis_after_nmi", req0, 0);
    $display("[TB] global-disable sequence done");

    // Reset asserted during REQ drops everything at the next edge.
    do_reset();
    ext_lines = 8'h01; ti_line = 1'b1;
    tick(); tick();
    check("rreq_req", req0, 1);
    check("rreq_mtip", mtip0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rreq_req_drop", req0, 0);
    check("rreq_pend", pend0, 0);
    check("rreq_mip", {meip0, msip0, mtip0}, 0);
    check("rreq_cause", cause0, 0);
    tick(); tick();
    check("rreq_idle_req", req0, 1);
    check("rreq_idle_cause", cause0, 16);
    $display("[TB] reset-during-request sequence done");

    // Two-stage synchroniser: a rising edge coinciding with the ack of that channel wins.
    do_reset();
    ext_lines = 8'h08; tick(); ext_lines = 8'h00;
    tick(); tick();
    check("sync_pend_lat", pend1[3], 1);
    check("sync_req_early", req1, 0);
    tick();
    check("sync_req", req1, 1);
    check("sync_cause", cause1, 19);
    ext_lines = 8'h08; tick(); ext_lines = 8'h00; tick();
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    check("sync_setwins_pend", pend1[3], 1);
    check("sync_setwins_gap", req1, 0);
    tick();
    check("sync_second_req", req1, 1);
    check("sync_second_cause", cause1, 19);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    check("sync_final_pend", pend1[3], 0);
    tick(); tick(); tick();
    check("sync_no_third", req1, 0);
    $display("[TB] synchroniser set-wins sequence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
